// File: rtl/dds_wave_gen.sv
// dds_wave_gen: single-channel DDS with shadowed bus registers, external sine ROM port,
// on-chip square/triangle/sawtooth, Q1.15 amplitude scaling and a wrap SYNC pulse.
module dds_wave_gen #(
  parameter logic [15:0] BASE_ADDR = 16'h0010,
  parameter int PHASE_W = 32,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 14
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cs_n,
  input  logic              i_wr_en,
  input  logic [15:0]       i_addr,
  input  logic [15:0]       i_data,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_q,
  output logic [DATA_W-1:0] o_da_out,
  output logic              o_sync
);
  localparam int L = DATA_W - ADDR_W;
  localparam logic [15:0] AMP_ONE = 16'h8000;
  logic w_wr;
  logic [5:0] w_sel;
  logic w_commit;
  logic w_ph_clr;
  logic [15:0] w_amp_in;
  assign w_wr = !i_cs_n && i_wr_en;
  for (genvar g = 0; g < 6; g++) begin : g_dec
    assign w_sel[g] = w_wr && (i_addr == BASE_ADDR + 16'(g));
  end
  assign w_commit = w_sel[5] && i_data[1];
  assign w_ph_clr = w_sel[5] && i_data[2];
  assign w_amp_in = (i_data > AMP_ONE) ? AMP_ONE : i_data;
  logic [31:0] r_freq_sh, r_freq_act;
  logic [15:0] r_poff_sh, r_poff_act;
  logic [1:0]  r_wsel_sh, r_wsel_act;
  logic [15:0] r_amp_sh, r_amp_act;
  logic        r_en;
  // commit copies the shadows as they stood before this edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_freq_sh  <= '0;
      r_poff_sh  <= '0;
      r_wsel_sh  <= '0;
      r_amp_sh   <= AMP_ONE;
      r_freq_act <= '0;
      r_poff_act <= '0;
      r_wsel_act <= '0;
      r_amp_act  <= AMP_ONE;
      r_en       <= 1'b0;
    end else begin
      if (w_sel[0]) r_freq_sh[15:0] <= i_data;
      if (w_sel[1]) r_freq_sh[31:16] <= i_data;
      if (w_sel[2]) r_poff_sh <= i_data;
      if (w_sel[3]) r_wsel_sh <= i_data[1:0];
      if (w_sel[4]) r_amp_sh <= w_amp_in;
      if (w_sel[5]) r_en <= i_data[0];
      if (w_commit) begin
        r_freq_act <= r_freq_sh;
        r_poff_act <= r_poff_sh;
        r_wsel_act <= r_wsel_sh;
        r_amp_act  <= r_amp_sh;
      end
    end
  end
  logic [PHASE_W-1:0] w_freq;
  if (PHASE_W > 32) begin : g_ext
    assign w_freq = {{(PHASE_W-32){1'b0}}, r_freq_act};
  end else begin : g_trunc
    assign w_freq = r_freq_act[PHASE_W-1:0];
  end
  logic [PHASE_W-1:0] r_acc;
  logic               r_wrap;
  logic [PHASE_W:0]   w_sum;
  assign w_sum = {1'b0, r_acc} + {1'b0, w_freq};
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_acc  <= w_ph_clr ? '0 : r_en ? w_sum[PHASE_W-1:0] : r_acc;
      r_wrap <= !w_ph_clr && r_en && w_sum[PHASE_W];
    end
  end
  logic [PHASE_W-1:0] w_phase;
  logic [ADDR_W-1:0]  w_p;
  assign w_phase = r_acc + {r_poff_act, {(PHASE_W-16){1'b0}}};
  assign w_p = ADDR_W'(w_phase >> (PHASE_W - ADDR_W));
  logic [ADDR_W-1:0] r_p2;
  logic [ADDR_W-2:0] w_t;
  logic [DATA_W-1:0] w_raw, r_raw;
  logic              r_w1, r_w2, r_w3;
  assign w_t = r_p2[ADDR_W-1] ? ~r_p2[ADDR_W-2:0] : r_p2[ADDR_W-2:0];
  always_comb begin
    w_raw = (r_wsel_act == 2'd0) ? i_rom_q :
            (r_wsel_act == 2'd1) ? {DATA_W{!r_p2[ADDR_W-1]}} :
            (r_wsel_act == 2'd2) ? DATA_W'({w_t, 1'b0}) << L :
                                   DATA_W'(r_p2) << L;
  end
  // offset binary to two's complement is an MSB flip; same on the way back
  logic signed [DATA_W-1:0]  w_s;
  logic signed [16:0]        w_amp;
  logic signed [DATA_W+16:0] w_prod;
  logic [DATA_W-1:0]         w_scaled;
  assign w_s      = {~r_raw[DATA_W-1], r_raw[DATA_W-2:0]};
  assign w_amp    = {1'b0, r_amp_act};
  assign w_prod   = (DATA_W+17)'(w_s) * (DATA_W+17)'(w_amp);
  assign w_scaled = DATA_W'(w_prod >>> 15);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rom_addr <= '0;
      r_p2       <= '0;
      r_raw      <= '0;
      r_w1       <= 1'b0;
      r_w2       <= 1'b0;
      r_w3       <= 1'b0;
      o_da_out   <= '0;
      o_sync     <= 1'b0;
    end else begin
      o_rom_addr <= w_p;
      r_w1       <= r_wrap;
      r_p2       <= o_rom_addr;
      r_w2       <= r_w1;
      r_raw      <= w_raw;
      r_w3       <= r_w2;
      o_da_out   <= {~w_scaled[DATA_W-1], w_scaled[DATA_W-2:0]};
      o_sync     <= r_w3;
    end
  end
endmodule

// File: tb/tb_dds_wave_gen.sv
// tb_dds_wave_gen: directed checks of dds_wave_gen (32/10/14) with a synchronous ROM model.
module tb_dds_wave_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data = '0;
  logic [9:0]  rom_addr;
  logic [13:0] rom_q = '0;
  logic [13:0] da_out;
  logic        sync;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  dds_wave_gen dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cs_n(cs_n), .i_wr_en(wr_en),
    .i_addr(addr), .i_data(data), .o_rom_addr(rom_addr), .i_rom_q(rom_q),
    .o_da_out(da_out), .o_sync(sync)
  );
  function automatic logic [13:0] rom(input logic [9:0] a);
    return 14'(a * 37);
  endfunction
  always @(posedge clk) rom_q <= rom(rom_addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    cs_n = 1'b0; wr_en = 1'b1; addr = a; data = d;
    @(negedge clk);
    cs_n = 1'b1; wr_en = 1'b0;
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_da", da_out, 0);
    chk("rst_rom", rom_addr, 0);
    chk("rst_sync", sync, 0);
    step(1);
    rst_n = 1'b1;
    step(10);
    chk("idle_da", da_out, 0);
    chk("idle_rom", rom_addr, 0);
    chk("idle_sync", sync, 0);
    // sawtooth, one ROM step per clock
    wr(16'h0010, 16'h0000);
    wr(16'h0011, 16'h0040);
    wr(16'h0013, 16'h0003);
    wr(16'h0014, 16'h8000);
    wr(16'h0015, 16'h0003);
    step(4);
    chk("saw0", da_out, 0);
    chk("saw0_sync", sync, 0);
    for (int j = 1; j <= 1030; j++) begin
      step(1);
      chk("saw", da_out, (16 * j) % 16384);
      chk("saw_sync", sync, 32'(j % 1024 == 0));
    end
    // square at half amplitude, phase toggling every clock
    wr(16'h0011, 16'h8000);
    wr(16'h0013, 16'h0001);
    wr(16'h0014, 16'h4000);
    wr(16'h0015, 16'h0007);
    step(4);
    for (int j = 0; j < 8; j++) begin
      chk("sq_half", da_out, (j % 2 == 0) ? 12287 : 4096);
      chk("sq_sync", sync, 32'(j >= 2 && j % 2 == 0));
      step(1);
    end
    wr(16'h0014, 16'hFFFF);
    wr(16'h0015, 16'h0007);
    step(4);
    for (int j = 0; j < 4; j++) begin
      chk("sq_clamp", da_out, (j % 2 == 0) ? 16383 : 0);
      step(1);
    end
    // frozen phase at half scale via offset
    wr(16'h0011, 16'h0000);
    wr(16'h0012, 16'h8000);
    wr(16'h0013, 16'h0003);
    wr(16'h0015, 16'h0007);
    step(5);
    chk("poff_rom", rom_addr, 512);
    chk("poff_saw", da_out, 8192);
    wr(16'h0013, 16'h0002);
    wr(16'h0015, 16'h0002);
    step(4);
    chk("poff_tri", da_out, 16352);
    // uncommitted FREQ_H must not alter the step
    wr(16'h0011, 16'h0040);
    wr(16'h0012, 16'h0000);
    wr(16'h0013, 16'h0003);
    wr(16'h0015, 16'h0007);
    wr(16'h0011, 16'h0080);
    step(3);
    chk("shadow0", da_out, 0);
    for (int j = 1; j <= 100; j++) begin
      step(1);
      chk("shadow_hold", da_out, 16 * j);
    end
    wr(16'h0015, 16'h0007);
    chk("commit_n", da_out, 1616);
    step(3);
    chk("commit_n3", da_out, 1664);
    step(1);
    chk("commit_n4", da_out, 0);
    step(1);
    chk("commit_n5", da_out, 32);
    step(1);
    chk("commit_n6", da_out, 64);
    // sine through the ROM model
    wr(16'h0013, 16'h0000);
    wr(16'h0011, 16'h0040);
    wr(16'h0015, 16'h0007);
    step(1);
    chk("sin_rom0", rom_addr, 0);
    step(1);
    chk("sin_rom1", rom_addr, 1);
    step(2);
    chk("sin_da0", da_out, 32'(rom(10'd0)));
    step(1);
    chk("sin_da1", da_out, 32'(rom(10'd1)));
    step(1);
    chk("sin_da2", da_out, 32'(rom(10'd2)));
    chk("sin_rom5", rom_addr, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_da", da_out, 0);
    chk("arst_rom", rom_addr, 0);
    chk("arst_sync", sync, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    chk("post_rst_da", da_out, 0);
    chk("post_rst_rom", rom_addr, 0);
    chk("post_rst_sync", sync, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dds_wave_gen.md
# dds_wave_gen

Parametrised single-channel DDS waveform generator for the DA path. It is programmed over the shared STM32–FPGA parallel bus. A PHASE_W-bit phase accumulator with a phase offset drives an external synchronous sine ROM, and square, triangle and sawtooth waves are computed on-chip. It adds Q1.15 amplitude scaling and a wrap SYNC pulse. All control registers are synchronous and shadowed, with an atomic commit, and feed a DA_OUT pipeline with a fixed latency.

## Interface
- BASE_ADDR, 16'h0010, bus address of register 0; registers occupy BASE_ADDR+0..+5
- PHASE_W, 32, phase accumulator width (≥ 17)
- ADDR_W, 10, ROM address width = top ADDR_W bits of phase
- DATA_W, 14, output and ROM data width, offset binary (DATA_W ≥ ADDR_W, ≤ 16)
- CLK  in  1  system clock; all logic on its rising edge
- RST_N  in  1  asynchronous active-low reset
- CS  in  1  bus chip select, active low
- WR_EN  in  1  bus write strobe, active high; a write occurs on each edge with !CS && WR_EN
- ADDR  in  16  bus address
- DATA  in  16  bus write data
- ROM_ADDR  out  ADDR_W  registered address to the external sine ROM
- ROM_Q  in  DATA_W  sine ROM data; 1-cycle synchronous ROM latency
- DA_OUT  out  DATA_W  scaled waveform sample
- SYNC  out  1  one-cycle pulse aligned with the first sample after a phase wrap

## Operation
- Registers, as offsets from BASE_ADDR:
  - +0 FREQ_L (shadow).
  - +1 FREQ_H (shadow); FREQ = {FREQ_H, FREQ_L}, truncated or zero-extended to PHASE_W.
  - +2 PHASE_OFF (shadow); left-justified into PHASE_W.
  - +3 WAVE_SEL[1:0] (shadow): 0 = sine, 1 = square, 2 = triangle, 3 = sawtooth.
  - +4 AMP (shadow), Q1.15; values above 16'h8000 clamp to 16'h8000.
  - +5 CTRL: bit0 EN (live), bit1 COMMIT (self-clearing strobe), bit2 PH_CLR (strobe).
- Writes to other addresses are ignored. There is no readback.
- COMMIT copies all shadows to the active set at the CTRL write edge. The copied values are the shadow contents before that edge.
- Accumulator: when EN=1, acc <= acc + FREQ_act (mod 2^PHASE_W); when EN=0, acc holds.
- PH_CLR forces acc <= 0 and overrides both the increment and EN.
- COMMIT and PH_CLR in the same write: acc <= 0 and the active set updates on the same edge; the next increment uses the new FREQ.
- Wrap: carry-out of the accumulator add sets wrap flag w, which is pipelined to SYNC.
- Phase p = top ADDR_W bits of (acc + PHASE_OFF_act << (PHASE_W-16)).
- Raw waveform, with L = DATA_W - ADDR_W:
  - sine: ROM_Q.
  - square: p[MSB]=0 → 2^DATA_W - 1, else 0.
  - sawtooth: p << L.
  - triangle: t = p[MSB] ? ~p[ADDR_W-2:0] : p[ADDR_W-2:0]; raw = {t, 1'b0} << L.
- Scaling: s = raw - 2^(DATA_W-1) (signed); DA_OUT = ((s * AMP_act) >>> 15) + 2^(DATA_W-1).
  - Arithmetic shift, floor rounding; no saturation is needed because |AMP| ≤ 1.0.

## Timing
- Reset values:
  - acc = 0; all pipeline registers, ROM_ADDR, DA_OUT and SYNC = 0.
  - Active and shadow registers: FREQ = 0, PHASE_OFF = 0, WAVE_SEL = 0, AMP = 16'h8000; EN = 0.
- Pipeline, where edge k updates acc:
  - k+1: ROM_ADDR and p1 <= p; w1 <= w.
  - k+2: ROM_Q valid; p2 <= p1.
  - k+3: raw <= mux by WAVE_SEL_act.
  - k+4: DA_OUT and SYNC registered.
- Latency from acc update to DA_OUT is 4 cycles.
- WAVE_SEL_act and AMP_act are used at their own stages, not delayed with the data. After a commit, up to 3 samples may mix the old and new settings.
- A register write at edge N affects the shadow only. A COMMIT at edge N changes the acc step at edge N+1; the first fully new sample appears at N+5.
- Asserting RST_N mid-operation clears everything immediately and asynchronously. Deassertion is synchronised externally.

## Test plan
- Reset, parameters 32/10/14 → DA_OUT=0, ROM_ADDR=0, SYNC=0. Hold 10 cycles with no writes → outputs unchanged.
- FREQ=32'h0040_0000, WAVE_SEL=3, AMP=16'h8000, then CTRL=3 → DA_OUT steps 0, 16, 32, … ≤ 16368. SYNC pulses every 1024 cycles, coincident with DA_OUT=0.
- Square with AMP=16'h4000 → DA_OUT alternates 12287 / 4096. AMP=16'hFFFF behaves as 16'h8000 → 16383 / 0.
- FREQ=0, PHASE_OFF=16'h8000, commit → ROM_ADDR=512. Sawtooth → DA_OUT=8192; triangle → DA_OUT=16352.
- Write FREQ_H without COMMIT → DA_OUT step unchanged for 100 cycles. Then COMMIT|PH_CLR|EN in one write → acc=0 at edge N; the new step is visible on DA_OUT from edge N+5.
- Sine via a ROM model: a ROM_Q value matching ROM_ADDR from 1 cycle earlier appears on DA_OUT 2 cycles later. Pulse RST_N low mid-run → all outputs 0 in the same cycle; EN=0 after release.
